// File: rtl/instr_decode.sv
// instr_decode: single-entry decode stage for a MIPS-like 32-bit ISA.
// Splits the fetched word into fields, classifies it, and extends the
// immediate. Register operands are read from a local 32x32 register file.
// The stage also holds off a consumer of a load still sitting in execute.
//
// Optional feature (compile-time macro):
//   DECODE_BYPASS_EN - a writeback in the same cycle as an accept supplies
//                      wb_data as the operand (write-through). When the macro
//                      is undefined, the operand is the value held before the
//                      write.
//
// Handshake: a fetch word is accepted on a rising edge where in_valid and
// in_ready are both high. A decoded bundle moves to execute on an edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, every out_* field holds.
module instr_decode #(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_shamt,
  output logic [4:0]  out_dest,
  output logic [31:0] out_imm,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val,
  output logic [2:0]  out_class,
  output logic        out_illegal,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd
);

  localparam logic [2:0] CLASS_RTYPE   = 3'd0;
  localparam logic [2:0] CLASS_ALU_IMM = 3'd1;
  localparam logic [2:0] CLASS_LOAD    = 3'd2;
  localparam logic [2:0] CLASS_STORE   = 3'd3;
  localparam logic [2:0] CLASS_BRANCH  = 3'd4;
  localparam logic [2:0] CLASS_JUMP    = 3'd5;
  localparam logic [2:0] CLASS_ILLEGAL = 3'd7;

  // Raw instruction fields.
  logic [5:0] ir_op;
  logic [5:0] ir_funct;
  logic [4:0] ir_rs;
  logic [4:0] ir_rt;
  logic [4:0] ir_rd;
  logic [4:0] ir_shamt;

  assign ir_op    = in_ir[31:26];
  assign ir_rs    = in_ir[25:21];
  assign ir_rt    = in_ir[20:16];
  assign ir_rd    = in_ir[15:11];
  assign ir_shamt = in_ir[10:6];
  assign ir_funct = in_ir[5:0];

  // Decoded values for the word currently presented.
  logic [2:0]  dec_class;
  logic        dec_illegal;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;
  logic        dec_uses_rt;

  // Classify the opcode, pick the destination and whether rt is a source.
  always_comb begin
    dec_class   = CLASS_ILLEGAL;
    dec_illegal = 1'b1;
    dec_dest    = 5'd0;
    dec_uses_rt = 1'b0;
    case (ir_op)
      6'h00: begin
        dec_class   = CLASS_RTYPE;
        dec_dest    = ir_rd;
        dec_uses_rt = 1'b1;
        case (ir_funct)
          6'h00, 6'h02, 6'h08, 6'h20, 6'h21,
          6'h22, 6'h24, 6'h25, 6'h2A: dec_illegal = 1'b0;
          default:                    dec_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        dec_class   = CLASS_ALU_IMM;
        dec_illegal = 1'b0;
        dec_dest    = ir_rt;
      end
      6'h23: begin
        dec_class   = CLASS_LOAD;
        dec_illegal = 1'b0;
        dec_dest    = ir_rt;
      end
      6'h2B: begin
        dec_class   = CLASS_STORE;
        dec_illegal = 1'b0;
        dec_uses_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_class   = CLASS_BRANCH;
        dec_illegal = 1'b0;
        dec_uses_rt = 1'b1;
      end
      6'h02: begin
        dec_class   = CLASS_JUMP;
        dec_illegal = 1'b0;
      end
      6'h03: begin
        dec_class   = CLASS_JUMP;
        dec_illegal = 1'b0;
        dec_dest    = 5'd31;
      end
      default: begin
        dec_class   = CLASS_ILLEGAL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Immediate extension: logical ops zero-extend, lui shifts up, jumps keep
  // the 26-bit target, everything else sign-extends.
  always_comb begin
    dec_imm = {{16{in_ir[15]}}, in_ir[15:0]};
    case (ir_op)
      6'h0C, 6'h0D: dec_imm = {16'h0000, in_ir[15:0]};
      6'h0F:        dec_imm = {in_ir[15:0], 16'h0000};
      6'h02, 6'h03: dec_imm = {6'b000000, in_ir[25:0]};
      default:      dec_imm = {{16{in_ir[15]}}, in_ir[15:0]};
    endcase
  end

  // Load-use hold: the incoming word reads the register a load in execute
  // has not yet produced. r0 never creates a dependency.
  logic hazard;
  assign hazard = (LOAD_USE_STALL != 0) && in_valid && ex_load_valid &&
                  (ex_load_rd != 5'd0) &&
                  ((ex_load_rd == ir_rs) || (dec_uses_rt && (ex_load_rd == ir_rt)));

  assign in_ready = (!out_valid || out_ready) && !flush && !hazard && !reset;

  logic accept;
  assign accept = in_valid && in_ready;

  // Register file; r0 is never written so it always reads zero.
  logic [31:0] regs [32];

  // Register file write port; reset clears every entry and wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Operand read at accept time.
  logic [31:0] rd_rs_val;
  logic [31:0] rd_rt_val;

  // Select operand source: register array, or the writeback in flight.
  always_comb begin
    rd_rs_val = regs[ir_rs];
    rd_rt_val = regs[ir_rt];
`ifdef DECODE_BYPASS_EN
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == ir_rs)) rd_rs_val = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == ir_rt)) rd_rt_val = wb_data;
`endif
  end

  // Output bundle register: load on accept, drop when consumed or flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'h0;
      out_opcode  <= 6'h0;
      out_funct   <= 6'h0;
      out_rs      <= 5'h0;
      out_rt      <= 5'h0;
      out_shamt   <= 5'h0;
      out_dest    <= 5'h0;
      out_imm     <= 32'h0;
      out_rs_val  <= 32'h0;
      out_rt_val  <= 32'h0;
      out_class   <= 3'h0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= ir_op;
      out_funct   <= ir_funct;
      out_rs      <= ir_rs;
      out_rt      <= ir_rt;
      out_shamt   <= ir_shamt;
      out_dest    <= dec_dest;
      out_imm     <= dec_imm;
      out_rs_val  <= rd_rs_val;
      out_rt_val  <= rd_rt_val;
      out_class   <= dec_class;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: table-driven decode checks plus directed sequences for
// backpressure, load-use hold, writeback bypass, flush and reset.
// Honors DECODE_BYPASS_EN to pick the expected same-cycle operand.
module tb_instr_decode;

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, out_ready, wb_en, ex_load_valid;
  logic [31:0] in_ir, in_pc, wb_data;
  logic [4:0]  wb_addr, ex_load_rd;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm, out_rs_val, out_rt_val;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_shamt, out_dest;
  logic [2:0]  out_class;

  logic        ns_in_ready, ns_out_valid, ns_out_illegal;
  logic [31:0] ns_out_pc, ns_out_imm, ns_out_rs_val, ns_out_rt_val;
  logic [5:0]  ns_out_opcode, ns_out_funct;
  logic [4:0]  ns_out_rs, ns_out_rt, ns_out_shamt, ns_out_dest;
  logic [2:0]  ns_out_class;

  instr_decode #(.LOAD_USE_STALL(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs),
    .out_rt(out_rt), .out_shamt(out_shamt), .out_dest(out_dest), .out_imm(out_imm),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_class(out_class),
    .out_illegal(out_illegal), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd)
  );

  instr_decode #(.LOAD_USE_STALL(0)) u_dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_pc(in_pc),
    .in_ready(ns_in_ready), .flush(flush), .out_ready(out_ready), .out_valid(ns_out_valid),
    .out_pc(ns_out_pc), .out_opcode(ns_out_opcode), .out_funct(ns_out_funct),
    .out_rs(ns_out_rs), .out_rt(ns_out_rt), .out_shamt(ns_out_shamt),
    .out_dest(ns_out_dest), .out_imm(ns_out_imm), .out_rs_val(ns_out_rs_val),
    .out_rt_val(ns_out_rt_val), .out_class(ns_out_class), .out_illegal(ns_out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd)
  );

  // Scoreboard
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [2:0]  cls;
    logic        illegal;
  } bundle_t;

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  cls;
    logic        ill;
    logic [4:0]  dest;
    logic [31:0] imm;
  } vec_t;

  bundle_t     exp_q[$];
  bundle_t     last;
  logic [31:0] reg_m [32];
  int          checks = 0;
  int          failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bundle_t make_exp(input logic [31:0] ir, input logic [31:0] pc,
                                       input logic [2:0] cls, input logic ill,
                                       input logic [4:0] dest, input logic [31:0] imm,
                                       input logic [31:0] rsv, input logic [31:0] rtv);
    bundle_t b;
    b.pc = pc;       b.opcode = ir[31:26]; b.funct = ir[5:0];
    b.rs = ir[25:21]; b.rt = ir[20:16];    b.shamt = ir[10:6];
    b.dest = dest;   b.imm = imm;          b.rs_val = rsv;
    b.rt_val = rtv;  b.cls = cls;          b.illegal = ill;
    return b;
  endfunction

  task automatic compare_bundle(input string tag, input bundle_t e);
    check({tag, ".valid"},   32'(out_valid),   32'd1);
    check({tag, ".pc"},      out_pc,           e.pc);
    check({tag, ".opcode"},  32'(out_opcode),  32'(e.opcode));
    check({tag, ".funct"},   32'(out_funct),   32'(e.funct));
    check({tag, ".rs"},      32'(out_rs),      32'(e.rs));
    check({tag, ".rt"},      32'(out_rt),      32'(e.rt));
    check({tag, ".shamt"},   32'(out_shamt),   32'(e.shamt));
    check({tag, ".dest"},    32'(out_dest),    32'(e.dest));
    check({tag, ".imm"},     out_imm,          e.imm);
    check({tag, ".rs_val"},  out_rs_val,       e.rs_val);
    check({tag, ".rt_val"},  out_rt_val,       e.rt_val);
    check({tag, ".class"},   32'(out_class),   32'(e.cls));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(e.illegal));
  endtask

  // Driver: present one word with out_ready high, expect it accepted, compare.
  task automatic drive_accept(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                              input logic [2:0] cls, input logic ill, input logic [4:0] dest,
                              input logic [31:0] imm, input logic [31:0] rsv,
                              input logic [31:0] rtv);
    bundle_t e;
    in_valid  = 1'b1;
    in_ir     = ir;
    in_pc     = pc;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(make_exp(ir, pc, cls, ill, dest, imm, rsv, rtv));
    tick();
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s.queue actual=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      compare_bundle(tag, e);
      last = e;
    end
  endtask

  task automatic wb_only(input logic [4:0] addr, input logic [31:0] data);
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
    if (addr != 5'd0) reg_m[addr] = data;
  endtask

  vec_t vecs [13];
  logic [4:0] vrs, vrt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    ex_load_valid = 1'b0; in_ir = 32'h0; in_pc = 32'h0; wb_data = 32'h0;
    wb_addr = 5'd0; ex_load_rd = 5'd0;
    for (int i = 0; i < 32; i++) reg_m[i] = 32'h0;

    vecs[0]  = '{32'h20A4_0005, 3'd1, 1'b0, 5'd4,  32'h0000_0005};
    vecs[1]  = '{32'h3C01_8000, 3'd1, 1'b0, 5'd1,  32'h8000_0000};
    vecs[2]  = '{32'h3021_FFFF, 3'd1, 1'b0, 5'd1,  32'h0000_FFFF};
    vecs[3]  = '{32'h0062_2020, 3'd0, 1'b0, 5'd4,  32'h0000_2020};
    vecs[4]  = '{32'h8C45_FFFC, 3'd2, 1'b0, 5'd5,  32'hFFFF_FFFC};
    vecs[5]  = '{32'hAC45_0010, 3'd3, 1'b0, 5'd0,  32'h0000_0010};
    vecs[6]  = '{32'h1043_FFFF, 3'd4, 1'b0, 5'd0,  32'hFFFF_FFFF};
    vecs[7]  = '{32'h0C00_0100, 3'd5, 1'b0, 5'd31, 32'h0000_0100};
    vecs[8]  = '{32'h08AB_CDEF, 3'd5, 1'b0, 5'd0,  32'h00AB_CDEF};
    vecs[9]  = '{32'hFC00_0000, 3'd7, 1'b1, 5'd0,  32'h0000_0000};
    vecs[10] = '{32'h0062_2023, 3'd0, 1'b1, 5'd4,  32'h0000_2023};
    vecs[11] = '{32'h34A6_FFFF, 3'd1, 1'b0, 5'd6,  32'h0000_FFFF};
    vecs[12] = '{32'h0005_1080, 3'd0, 1'b0, 5'd2,  32'h0000_1080};

    // Reset: in_ready low while reset is high, all outputs cleared.
    in_valid = 1'b1; in_ir = 32'h20A4_0005;
    tick();
    check("reset.in_ready", 32'(in_ready), 32'd0);
    tick();
    check("reset.in_ready2", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_pc", out_pc, 32'h0);
    check("reset.out_imm", out_imm, 32'h0);
    check("reset.out_dest", 32'(out_dest), 32'h0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("post_reset.out_valid", 32'(out_valid), 32'd0);

    // Preload operands.
    wb_only(5'd2, 32'h0000_0022);
    wb_only(5'd3, 32'h0000_0033);
    wb_only(5'd5, 32'h0000_0055);
    wb_only(5'd4, 32'h0000_0044);

    // Table of decode vectors, back-to-back.
    for (int i = 0; i < 13; i++) begin
      vrs = vecs[i].ir[25:21];
      vrt = vecs[i].ir[20:16];
      drive_accept($sformatf("vec%0d", i), vecs[i].ir, 32'h1000 + 32'(i * 4), vecs[i].cls,
                   vecs[i].ill, vecs[i].dest, vecs[i].imm, reg_m[vrs], reg_m[vrt]);
    end
    out_ready = 1'b1;
    tick();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: hold 3 cycles, writeback to a held operand must not leak.
    drive_accept("stallA", 32'h20A4_0005, 32'h100, 3'd1, 1'b0, 5'd4, 32'h5, reg_m[5], reg_m[4]);
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h3C01_8000; in_pc = 32'h104;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_AAAA;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      tick();
      wb_en = 1'b0;
      compare_bundle($sformatf("stall%0d", c), last);
    end
    reg_m[5] = 32'h0000_AAAA;
    drive_accept("stallB", 32'h3C01_8000, 32'h104, 3'd1, 1'b0, 5'd1, 32'h8000_0000,
                 reg_m[0], reg_m[1]);
    tick();

    // Load-use hold on rs of an R-type; the LOAD_USE_STALL=0 copy takes it.
    ex_load_valid = 1'b1; ex_load_rd = 5'd3;
    in_valid = 1'b1; in_ir = 32'h0062_2020; in_pc = 32'h200; out_ready = 1'b1;
    #1;
    check("hz.in_ready", 32'(in_ready), 32'd0);
    check("hz.ns_in_ready", 32'(ns_in_ready), 32'd1);
    tick();
    check("hz.out_valid", 32'(out_valid), 32'd0);
    check("hz.ns_out_valid", 32'(ns_out_valid), 32'd1);
    check("hz.ns_out_pc", ns_out_pc, 32'h200);
    check("hz.in_ready2", 32'(in_ready), 32'd0);
    ex_load_valid = 1'b0;
    drive_accept("hz_go", 32'h0062_2020, 32'h200, 3'd0, 1'b0, 5'd4, 32'h2020,
                 reg_m[3], reg_m[2]);
    // rt of an ALU-imm is a destination, not a source: no hold.
    ex_load_valid = 1'b1; ex_load_rd = 5'd4;
    drive_accept("hz_imm_rt", 32'h20A4_0005, 32'h204, 3'd1, 1'b0, 5'd4, 32'h5,
                 reg_m[5], reg_m[4]);
    // rt of a store is a source: hold.
    ex_load_rd = 5'd5; in_valid = 1'b1; in_ir = 32'hAC45_0010; out_ready = 1'b1;
    #1;
    check("hz_store_rt.in_ready", 32'(in_ready), 32'd0);
    // Load into r0 never holds.
    ex_load_rd = 5'd0;
    drive_accept("hz_r0", 32'h3C01_8000, 32'h208, 3'd1, 1'b0, 5'd1, 32'h8000_0000,
                 32'h0, reg_m[1]);
    ex_load_valid = 1'b0;

    // Same-cycle writeback to an operand being read.
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    drive_accept("byp", 32'h20E8_0001, 32'h300, 3'd1, 1'b0, 5'd8, 32'h1,
                 BYPASS ? 32'h0000_1234 : reg_m[7], reg_m[8]);
    wb_en = 1'b0; reg_m[7] = 32'h0000_1234;
    drive_accept("byp_after", 32'h20E8_0001, 32'h304, 3'd1, 1'b0, 5'd8, 32'h1,
                 reg_m[7], reg_m[8]);
    // Write to r0 is dropped even when bypassing.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_DEAD;
    drive_accept("r0_wb", 32'h3C01_8000, 32'h308, 3'd1, 1'b0, 5'd1, 32'h8000_0000,
                 32'h0, reg_m[1]);
    wb_en = 1'b0;
    drive_accept("r0_read", 32'h3C01_8000, 32'h30C, 3'd1, 1'b0, 5'd1, 32'h8000_0000,
                 32'h0, reg_m[1]);

    // Flush while stalled, with out_ready also high; writeback still lands.
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0062_2020;
    #1;
    check("fl_stall.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b1; out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
    #1;
    check("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0; reg_m[9] = 32'h0000_0099;
    check("flush.out_valid", 32'(out_valid), 32'd0);
    drive_accept("fl_wb", 32'h212A_0001, 32'h400, 3'd1, 1'b0, 5'd10, 32'h1,
                 reg_m[9], reg_m[10]);

    // Reset during a stall with a pending write.
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h0062_2020;
    tick();
    reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_0077;
    #1;
    check("rst_stall.in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 32; i++) reg_m[i] = 32'h0;
    check("rst_stall.out_valid", 32'(out_valid), 32'd0);
    check("rst_stall.out_pc", out_pc, 32'h0);
    check("rst_stall.out_rs_val", out_rs_val, 32'h0);
    drive_accept("rst_regs", 32'h212A_0001, 32'h500, 3'd1, 1'b0, 5'd10, 32'h1,
                 reg_m[9], reg_m[10]);

    // Final report
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard.leftover actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The module SHALL have parameter LOAD_USE_STALL, default 1, which enables the load-use hazard hold when 1.
REQ-002 The module SHALL have these ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  fetch word valid.
- in_ir  input  32  instruction word.
- in_pc  input  32  PC of in_ir.
- in_ready  output  1  stage can accept.
- flush  input  1  discard held instruction.
- out_ready  input  1  execute can accept.
- out_valid  output  1  decoded bundle valid.
- out_pc  output  32  captured PC.
- out_opcode/out_funct  output  6 each  ir[31:26], ir[5:0].
- out_rs/out_rt/out_shamt  output  5 each  ir[25:21], ir[20:16], ir[10:6].
- out_dest  output  5  destination register.
- out_imm  output  32  extended immediate.
- out_rs_val/out_rt_val  output  32 each  register operands.
- out_class  output  3  instruction class.
- out_illegal  output  1  unknown opcode or funct.
- wb_en/wb_addr/wb_data  input  1/5/32  register-file write port.
- ex_load_valid/ex_load_rd  input  1/5  load in execute and its destination.

Function
REQ-003 Accept SHALL occur when in_valid and in_ready are both high; all out_* fields SHALL update at that edge with one-cycle latency.
REQ-004 in_ready SHALL equal (!out_valid | out_ready) & !flush & !hazard.
REQ-005 While out_valid & !out_ready, every out_* SHALL hold stable.
REQ-006 out_valid SHALL be set on accept, cleared when out_ready is high and there is no accept, and otherwise held.
REQ-007 Class encoding SHALL be:
- 0 R-type: op 0x00.
- 1 ALU-imm: 0x08, 0x09, 0x0A, 0x0C, 0x0D, 0x0F.
- 2 load: 0x23.
- 3 store: 0x2B.
- 4 branch: 0x04, 0x05.
- 5 jump: 0x02, 0x03.
- 7 illegal: any other opcode, with out_illegal=1.
REQ-008 For R-type, funct outside {0x00, 0x02, 0x08, 0x20, 0x21, 0x22, 0x24, 0x25, 0x2A} SHALL set out_illegal=1, class 0.
REQ-009 out_imm SHALL be:
- zero-extended ir[15:0] for 0x0C and 0x0D.
- {ir[15:0], 16'h0} for 0x0F.
- {6'b0, ir[25:0]} for jumps.
- sign-extended ir[15:0] otherwise.
REQ-010 out_dest SHALL be:
- rd for R-type.
- rt for ALU-imm and load.
- 31 for 0x03.
- 0 otherwise.
REQ-011 The register file SHALL be 32x32, written at the edge when wb_en=1. Writes to r0 SHALL be ignored and r0 SHALL always read 0.
REQ-012 Operands SHALL be read at accept time. Later writebacks SHALL NOT alter the held out_rs_val/out_rt_val.
REQ-013 hazard SHALL be 1 when all of the following hold; otherwise 0:
- LOAD_USE_STALL=1, in_valid=1, ex_load_valid=1 and ex_load_rd!=0.
- ex_load_rd equals in_ir rs, or equals rt for R-type, store or branch.
REQ-014 When flush=1, out_valid SHALL be 0 next cycle and no accept SHALL occur. Register-file writes SHALL still occur during flush.
REQ-015 When flush and out_ready are high together, flush SHALL take precedence.

Reset
REQ-016 On reset at the clock edge:
- out_valid, every out_* field and all 32 registers SHALL become 0.
- in_ready SHALL be 0 during the reset cycle.
REQ-017 Reset during a stall SHALL discard the held instruction, and no pending wb write SHALL land that cycle.

Configuration
REQ-018 With DECODE_BYPASS_EN defined, a same-cycle wb_en write to a nonzero register read by the accepted instruction SHALL supply wb_data as the operand (write-through).
REQ-019 Without DECODE_BYPASS_EN, the operand SHALL be the pre-write register value.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then accept 0x20A4_0005 (addi r4,r5,5): next cycle class=1, dest=4, rs=5, imm=0x0000_0005, out_valid=1.
- Accept 0x3C01_8000 (lui r1): imm=0x8000_0000. Accept 0x3021_FFFF (andi): imm=0x0000_FFFF.
- out_ready=0 for 3 cycles with in_valid=1: in_ready=0 and outputs stable, then the next word is accepted on the first out_ready=1 cycle.
- ex_load_valid=1, ex_load_rd=3, in_ir=0x0062_2020 (add r4,r3,r2): in_ready=0 until ex_load_valid drops. With LOAD_USE_STALL=0, accepted immediately.
- wb r7=0x1234 in the same cycle as accepting an instruction reading r7: out_rs_val=0x1234 with DECODE_BYPASS_EN, and 0 without it. A write to r0 always reads 0.
- flush while stalled: out_valid=0 next cycle. Opcode 0x3F gives out_illegal=1, class=7.
